// File: rtl/bomb_controller.sv
// Per-player bomb sequencer: latches drop position, runs fuse, strobes bombEnable, then cooldown.
// Optional BOMB_REMOTE_DET_EN: a fresh press while armed detonates the bomb early.
module bomb_controller #(
    parameter int N            = 50000000,
    parameter int FUSE_SEC     = 3,
    parameter int BLAST_CYCLES = 2,
    parameter int COOLDOWN_SEC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       drop,
    input  logic [5:0] playerPosX,
    input  logic [5:0] playerPosY,
    input  logic       stunned,
    output logic [5:0] bombPosX,
    output logic [5:0] bombPosY,
    output logic       bombArmed,
    output logic       bombEnable,
    output logic       ready
);

    localparam int MAXSEC = (FUSE_SEC > COOLDOWN_SEC) ? FUSE_SEC
                          : ((COOLDOWN_SEC > 1) ? COOLDOWN_SEC : 1);
    localparam int CW = $clog2(N * MAXSEC + 1);
    localparam int COOL_SEC_NZ = (COOLDOWN_SEC > 0) ? COOLDOWN_SEC : 1;

    localparam logic [CW-1:0] FUSE_LOAD  = CW'(N * FUSE_SEC - 1);
    localparam logic [CW-1:0] BLAST_LOAD = CW'(BLAST_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LOAD  = CW'(N * COOL_SEC_NZ - 1);

    typedef enum logic [1:0] {IDLE, ARMED, BLAST, COOLDOWN} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] counter, counterNext;
    logic [5:0]    posXNext, posYNext;
    logic          dropQ;
    logic          dropEdge;

    assign dropEdge   = drop & ~dropQ;
    assign ready      = (state == IDLE);
    assign bombArmed  = (state == ARMED);
    assign bombEnable = (state == BLAST);

    // dropQ resets high so a button held through reset release is not seen as a press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            bombPosX <= '0;
            bombPosY <= '0;
            dropQ    <= 1'b1;
        end else begin
            state    <= stateNext;
            counter  <= counterNext;
            bombPosX <= posXNext;
            bombPosY <= posYNext;
            dropQ    <= drop;
        end
    end

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        posXNext    = bombPosX;
        posYNext    = bombPosY;
        case (state)
            IDLE: begin
                if (dropEdge && !stunned) begin
                    stateNext   = ARMED;
                    counterNext = FUSE_LOAD;
                    posXNext    = playerPosX;
                    posYNext    = playerPosY;
                end
            end
            ARMED: begin
                counterNext = counter - CW'(1);
                if (counter == '0) begin
                    stateNext   = BLAST;
                    counterNext = BLAST_LOAD;
                end
`ifdef BOMB_REMOTE_DET_EN
                if (dropEdge && !stunned) begin
                    stateNext   = BLAST;
                    counterNext = BLAST_LOAD;
                end
`endif
            end
            BLAST: begin
                counterNext = counter - CW'(1);
                if (counter == '0) begin
                    if (COOLDOWN_SEC > 0) begin
                        stateNext   = COOLDOWN;
                        counterNext = COOL_LOAD;
                    end else begin
                        stateNext   = IDLE;
                        counterNext = '0;
                    end
                end
            end
            COOLDOWN: begin
                counterNext = counter - CW'(1);
                if (counter == '0) begin
                    stateNext   = IDLE;
                    counterNext = '0;
                end
            end
            default: begin
                stateNext   = IDLE;
                counterNext = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bomb_controller.sv
// Bench for bomb_controller: directed scenarios plus random traffic against a timestamp-based model.
module tb_bomb_controller;

    localparam int N     = 4;
    localparam int FUSE  = N * 3;
    localparam int BL    = 2;
    localparam int NCOOL = N * 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       drop = 1'b1;
    logic [5:0] playerPosX = '0, playerPosY = '0;
    logic       stunned = 1'b0;
    logic [5:0] bombPosX, bombPosY;
    logic       bombArmed, bombEnable, ready;

    int checks = 0;
    int failures = 0;

    // model: phases are derived from the accept edge and the detonation edge
    int         edgeIdx = 0;
    bit         hasBomb = 0;
    int         blastEdge = 0;
    logic [5:0] mPosX = '0, mPosY = '0;
    logic       prevDrop = 1'b1;

    bomb_controller #(.N(N), .FUSE_SEC(3), .BLAST_CYCLES(BL), .COOLDOWN_SEC(2)) dut (
        .clk(clk), .reset(reset), .drop(drop),
        .playerPosX(playerPosX), .playerPosY(playerPosY), .stunned(stunned),
        .bombPosX(bombPosX), .bombPosY(bombPosY),
        .bombArmed(bombArmed), .bombEnable(bombEnable), .ready(ready)
    );

    always #5 clk = ~clk;

    // 0 idle, 1 fuse running, 2 blast, 3 cooldown, as seen just after edge e
    function automatic int phaseAt(int e);
        if (!hasBomb)                   return 0;
        if (e < blastEdge)              return 1;
        if (e < blastEdge + BL)         return 2;
        if (e < blastEdge + BL + NCOOL) return 3;
        return 0;
    endfunction

    task automatic chk(string tag, logic [5:0] obs, logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, edgeIdx);
        end
    endtask

    task automatic checkAll();
        int ph;
        ph = phaseAt(edgeIdx);
        chk("ready",      {5'd0, ready},      {5'd0, ph == 0});
        chk("bombArmed",  {5'd0, bombArmed},  {5'd0, ph == 1});
        chk("bombEnable", {5'd0, bombEnable}, {5'd0, ph == 2});
        chk("bombPosX",   bombPosX, mPosX);
        chk("bombPosY",   bombPosY, mPosY);
    endtask

    task automatic modelReset();
        hasBomb  = 0;
        mPosX    = '0;
        mPosY    = '0;
        prevDrop = 1'b1;
    endtask

    task automatic tick();
        bit pressed;
        @(posedge clk);
        edgeIdx++;
        if (reset) modelReset();
        else begin
            pressed = drop && !prevDrop;
            if (phaseAt(edgeIdx - 1) == 0 && pressed && !stunned) begin
                hasBomb   = 1;
                blastEdge = edgeIdx + FUSE;
                mPosX     = playerPosX;
                mPosY     = playerPosY;
            end
`ifdef BOMB_REMOTE_DET_EN
            else if (phaseAt(edgeIdx - 1) == 1 && pressed && !stunned)
                blastEdge = edgeIdx;
`endif
            prevDrop = drop;
        end
        @(negedge clk);
        checkAll();
    endtask

    task automatic pulse();
        drop = 1'b0; tick();
        drop = 1'b1; tick();
        drop = 1'b0;
    endtask

    task automatic runN(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int cnt;
        modelReset();
        #1;
        checkAll();
        runN(2);
        @(negedge clk) reset = 1'b0;
        runN(3);

        // 1: basic sequence, ready returns 22 edges after accept
        playerPosX = 6'd10; playerPosY = 6'd20;
        pulse();
        cnt = 0;
        while (!ready && cnt < 60) begin tick(); cnt++; end
        chk("drop_to_ready", 6'(cnt), 6'd22);

        // 2: held button fires once
        drop = 1'b1;
        runN(40);
        drop = 1'b0;
        runN(5);
        chk("held_no_rearm", {5'd0, bombArmed}, 6'd0);

        // 3: stunned press discarded, later press accepted
        stunned = 1'b1;
        pulse(); runN(3);
        chk("stunned_ready", {5'd0, ready}, 6'd1);
        stunned = 1'b0;
        pulse();
        chk("unstunned_arm", {5'd0, bombArmed}, 6'd1);
        runN(25);

        // 4: movement during fuse does not disturb latched position
        playerPosX = 6'd10; playerPosY = 6'd20;
        pulse(); runN(3);
        playerPosX = 6'd11; playerPosY = 6'd21;
        runN(25);
        chk("pos_hold_x", bombPosX, 6'd10);

        // 5: async reset mid-blast with drop held across release
        pulse();
        cnt = 0;
        while (!bombEnable && cnt < 40) begin tick(); cnt++; end
        chk("reached_blast", {5'd0, bombEnable}, 6'd1);
        drop = 1'b1;
        #1 reset = 1'b1;
        #1;
        modelReset();
        chk("rst_enable", {5'd0, bombEnable}, 6'd0);
        chk("rst_ready",  {5'd0, ready},      6'd1);
        chk("rst_posx",   bombPosX, 6'd0);
        chk("rst_posy",   bombPosY, 6'd0);
        runN(2);
        reset = 1'b0;
        runN(6);
        chk("no_arm_after_rst", {5'd0, bombArmed}, 6'd0);
        drop = 1'b0;
        runN(2);

        // 6: second press at fuse cycle 5
        pulse();
        runN(4);
        drop = 1'b1; tick(); drop = 1'b0;
`ifdef BOMB_REMOTE_DET_EN
        chk("remote_det", {5'd0, bombEnable}, 6'd1);
`else
        chk("no_remote_det", {5'd0, bombEnable}, 6'd0);
`endif
        runN(30);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            drop       = ($urandom_range(0, 3) == 0);
            stunned    = ($urandom_range(0, 4) == 0);
            playerPosX = 6'($urandom_range(0, 63));
            playerPosY = 6'($urandom_range(0, 63));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
